// File: rtl/serial_vec_sum.sv
// ============================================================================
// serial_vec_sum
//
// Collects a frame of DEPTH words into a register vector, then adds the
// stored entries one per cycle and offers the frame sum downstream with a
// valid/ready handshake. Only one frame is in flight at a time: the next
// frame is loaded only after the current sum has been taken.
//
// Parameters
//   WIDTH      data and sum width in bits
//   DEPTH      words per frame (legal range 2..16)
//
// Ports
//   clk        clock, all state changes on the rising edge
//   reset      synchronous, active-high reset
//   in_valid   upstream word present on in_data
//   in_ready   block accepts a word this cycle (LOAD and not in reset)
//   in_data    input word
//   out_valid  out_sum holds a completed frame sum
//   out_ready  downstream accepts out_sum
//   out_sum    frame sum (unsigned, modulo 2^WIDTH), zero while out_valid=0
// ============================================================================
module serial_vec_sum #(
    parameter int WIDTH = 32,
    parameter int DEPTH = 6
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_data,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_sum
);

    // Index width covers 0..DEPTH-1; DEPTH is at least 2 so this is >= 1.
    localparam int               IDX_W    = (DEPTH > 2) ? $clog2(DEPTH) : 1;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(DEPTH - 1);
    localparam logic [IDX_W-1:0] IDX_ONE  = IDX_W'(1);
    localparam logic [IDX_W-1:0] IDX_ZERO = IDX_W'(0);
    localparam logic [WIDTH-1:0] ACC_ZERO = WIDTH'(0);

    typedef enum logic [1:0] {
        LOAD = 2'd0,
        SUM  = 2'd1,
        OUT  = 2'd2
    } state_t;

    state_t           state_r;
    state_t           state_s;
    logic [IDX_W-1:0] idx_r;
    logic [IDX_W-1:0] idx_s;
    logic [WIDTH-1:0] acc_r;
    logic [WIDTH-1:0] acc_s;
    logic [WIDTH-1:0] entry_r [DEPTH];
    logic             wr_en_s;
    logic             last_s;

    // The current index points at the final entry of the frame.
    assign last_s = (idx_r == LAST_IDX);

    // State, index and accumulator registers.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_r <= LOAD;
            idx_r   <= IDX_ZERO;
            acc_r   <= ACC_ZERO;
        end else begin
            state_r <= state_s;
            idx_r   <= idx_s;
            acc_r   <= acc_s;
        end
    end

    // Frame storage: written only on an accepted word, cleared by reset.
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < DEPTH; i++) begin
                entry_r[i] <= ACC_ZERO;
            end
        end else if (wr_en_s) begin
            entry_r[idx_r] <= in_data;
        end
    end

    // Next-state, next-index, next-accumulator and write-enable decode.
    always_comb begin
        state_s = state_r;
        idx_s   = idx_r;
        acc_s   = acc_r;
        wr_en_s = 1'b0;
        case (state_r)
            LOAD: begin
                // in_ready is 1 here, so in_valid alone marks an accept.
                // A gap in in_valid leaves index and entries untouched.
                if (in_valid) begin
                    wr_en_s = 1'b1;
                    if (last_s) begin
                        state_s = SUM;
                        idx_s   = IDX_ZERO;
                        acc_s   = ACC_ZERO;
                    end else begin
                        idx_s = idx_r + IDX_ONE;
                    end
                end else begin
                    wr_en_s = 1'b0;
                end
            end
            SUM: begin
                // One entry per cycle; carries out of WIDTH are dropped.
                acc_s = acc_r + entry_r[idx_r];
                if (last_s) begin
                    state_s = OUT;
                    idx_s   = IDX_ZERO;
                end else begin
                    idx_s = idx_r + IDX_ONE;
                end
            end
            OUT: begin
                // The sum is held in acc_r until downstream takes it.
                if (out_ready) begin
                    state_s = LOAD;
                    idx_s   = IDX_ZERO;
                end else begin
                    state_s = OUT;
                end
            end
            default: begin
                // Unreachable encoding: fall back to a clean empty frame.
                state_s = LOAD;
                idx_s   = IDX_ZERO;
                acc_s   = ACC_ZERO;
            end
        endcase
    end

    // Handshake outputs come from the state register only; reset masks
    // in_ready so nothing is taken while the block is being cleared.
    assign in_ready  = (state_r == LOAD) && !reset;
    assign out_valid = (state_r == OUT);
    assign out_sum   = out_valid ? acc_r : ACC_ZERO;

endmodule
